urv_trap_ctrl: RTL and testbench
================================

URV_TRAP_CTRL -- requirements
Module: urv_trap_ctrl

Interface
REQ-001 Parameter g_NUM_IRQ, default 4, SHALL set the external interrupt line count; legal range 1..16.
REQ-002 Parameter g_EDGE_MASK, default 0, SHALL select per-line triggering: bit n=1 edge-triggered line n, 0 level-triggered.
REQ-003 Parameter g_VECTORED, default 1, SHALL enable vectored mtvec mode; when 0, mtvec[1:0] SHALL read 0.
REQ-004 Parameter g_MTVEC_RESET, default 32'h00000008, SHALL set the mtvec reset value.
REQ-005 Ports SHALL be:
  clk_i  in  1  sole clock; all state on rising edge
  rst_n_i  in  1  asynchronous active-low reset
  x_stall_i, x_kill_i  in  1  execute-stage stall / kill
  d_is_csr_i, d_is_mret_i  in  1  CSR access / MRET in execute
  d_csr_sel_i  in  12  CSR address
  x_csr_write_value_i  in  32  computed CSR write data
  irq_i  in  g_NUM_IRQ  external interrupt lines, synchronous to clk_i
  tick_i  in  1  timer interrupt request, level
  x_exception_i  in  1  trap taken this cycle
  x_interrupt_i  in  1  trap is an interrupt
  x_exception_cause_i  in  5  trap cause code
  x_exception_pc_i  in  32  PC to save
  irq_pending_o  out  1  enabled interrupt pending
  irq_cause_o  out  5  cause code of highest-priority pending interrupt
  x_trap_vector_o  out  32  trap target address
  x_exception_pc_o  out  32  mepc, MRET target
  csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mtvec_o, csr_mscratch_o, csr_mepc_o, csr_mcause_o  out  32  CSR read values

Function
REQ-006 CSR write SHALL occur only when d_is_csr_i=1, x_stall_i=0, x_kill_i=0, addressed by d_csr_sel_i: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x344 mip; other addresses ignored.
REQ-007 mstatus SHALL implement MIE bit 3 and MPIE bit 7, MPP [12:11] reading 2'b11, all other bits 0.
REQ-008 mie SHALL implement bit 7 (timer) and bits 16+n for n<g_NUM_IRQ; other bits read 0 and ignore writes.
REQ-009 mip bit 7 SHALL be tick_i registered each cycle; bit 16+n SHALL be irq_i[n] registered (level line) or the edge-pending flag (edge line); mip writes affect only edge flags.
REQ-010 Edge flag n SHALL set on a registered 0->1 transition of irq_i[n]; a mip write SHALL clear flags whose written bit is 0; set SHALL win over a same-cycle clear.
REQ-011 Taking an interrupt (x_exception_i=1, x_interrupt_i=1, cause 16+n) SHALL clear edge flag n unless a new edge sets it in the same cycle.
REQ-012 irq_pending_o SHALL equal MIE AND OR(mip AND mie), combinational from registered state.
REQ-013 irq_cause_o SHALL encode priority: lowest-index external line highest (16+n), timer (7) lowest; 0 when nothing pending.
REQ-014 On x_exception_i=1: mepc<=x_exception_pc_i with [1:0]=0; mcause<={x_interrupt_i,26'b0,x_exception_cause_i}; MPIE<=MIE; MIE<=0 (exceptions and interrupts alike).
REQ-015 On MRET (d_is_mret_i=1, x_stall_i=0, x_kill_i=0): MIE<=MPIE; MPIE<=1.
REQ-016 Same-cycle priority SHALL be trap over MRET over CSR write; losing actions are discarded entirely.
REQ-017 x_trap_vector_o SHALL be {mtvec[31:2],2'b00}, plus 4*x_exception_cause_i when mtvec[1:0]=1 and x_interrupt_i=1; mtvec[1:0] writes of 2 or 3 SHALL store 0.
REQ-018 mepc writes SHALL force [1:0]=0; mcause writes SHALL keep only bits 31 and 4:0; mscratch is fully read/write.
REQ-019 x_exception_pc_o SHALL equal mepc.

Reset
REQ-020 rst_n_i low SHALL immediately clear mepc, mcause, mscratch, mie, MIE, MPIE, edge flags, registered irq/tick samples; mtvec<=g_MTVEC_RESET (mode bits masked per REQ-003).
REQ-021 During reset irq_pending_o=0, irq_cause_o=0, x_exception_pc_o=0; an edge present when reset releases SHALL NOT register (sample starts from 0 only after the first post-reset clock, per REQ-020).

Verification
REQ-022 Write mie=0x00010080, mstatus=0x8, raise tick_i -> one edge later irq_pending_o=1, irq_cause_o=7.
REQ-023 Lines 0 and 2 both pending and enabled with tick_i -> irq_cause_o=16; clear line 0 -> 18.
REQ-024 Edge line 1 pulsed one cycle -> flag held; trap with cause 17 clears it; pulse coinciding with trap keeps flag set.
REQ-025 mtvec=0x00001001, trap x_interrupt_i=1 cause 16 -> x_trap_vector_o=0x00001040; exception cause 2 -> 0x00001000.
REQ-026 MIE=1, trap -> MIE=0, MPIE=1, mepc=PC; MRET -> MIE=1, MPIE=1; trap+MRET+mstatus write same cycle -> only trap effects.
REQ-027 Assert rst_n_i asynchronously mid-operation -> all CSRs at reset values before next clock edge, mtvec=0x00000008.

Source files
------------

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt pending/priority logic and trap/MRET sequencing.
// Edge-triggered lines latch a pending flag; level lines follow the registered input.
module urv_trap_ctrl #(
   parameter int unsigned g_NUM_IRQ     = 4,
   parameter logic [15:0] g_EDGE_MASK   = 16'h0000,
   parameter bit          g_VECTORED    = 1'b1,
   parameter logic [31:0] g_MTVEC_RESET = 32'h0000_0008
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 x_stall_i,
   input  logic                 x_kill_i,
   input  logic                 d_is_csr_i,
   input  logic                 d_is_mret_i,
   input  logic [11:0]          d_csr_sel_i,
   input  logic [31:0]          x_csr_write_value_i,
   input  logic [g_NUM_IRQ-1:0] irq_i,
   input  logic                 tick_i,
   input  logic                 x_exception_i,
   input  logic                 x_interrupt_i,
   input  logic [4:0]           x_exception_cause_i,
   input  logic [31:0]          x_exception_pc_i,
   output logic                 irq_pending_o,
   output logic [4:0]           irq_cause_o,
   output logic [31:0]          x_trap_vector_o,
   output logic [31:0]          x_exception_pc_o,
   output logic [31:0]          csr_mstatus_o,
   output logic [31:0]          csr_mie_o,
   output logic [31:0]          csr_mip_o,
   output logic [31:0]          csr_mtvec_o,
   output logic [31:0]          csr_mscratch_o,
   output logic [31:0]          csr_mepc_o,
   output logic [31:0]          csr_mcause_o
);

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam logic [15:0] IRQ_MASK  = 16'((32'd1 << g_NUM_IRQ) - 32'd1);
   localparam logic [15:0] EDGE_MASK = g_EDGE_MASK & IRQ_MASK;
   localparam logic [31:0] MIE_MASK  = {IRQ_MASK, 16'h0080};
   localparam logic [31:0] MTVEC_RST = {g_MTVEC_RESET[31:2],
      (g_VECTORED && (g_MTVEC_RESET[1:0] == 2'b01)) ? 2'b01 : 2'b00};

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] csr_mie_q, csr_mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic        tick_q;
   logic [15:0] irq_q;
   logic [15:0] edge_q, edge_d;
   logic        armed_q;

   logic        trap, mret_req, mret, csr_we;
   logic [31:0] wdata;
   logic [15:0] irq_in, edge_set, take_clr, wr_clr, mip_ext;
   logic [31:0] mip_r, pend;
   logic [4:0]  irq_cause;
   logic [31:0] vec_offset;

   assign irq_in = 16'(irq_i);
   assign wdata  = x_csr_write_value_i;

   // Trap beats MRET beats CSR write; the loser's side effects are dropped.
   always_comb begin
      trap     = x_exception_i;
      mret_req = d_is_mret_i & ~x_stall_i & ~x_kill_i;
      mret     = mret_req & ~trap;
      csr_we   = d_is_csr_i & ~x_stall_i & ~x_kill_i & ~trap & ~mret_req;
   end

   // armed_q masks the first post-reset sample so a line already high at release is not an edge.
   always_comb begin
      edge_set = irq_in & ~irq_q & EDGE_MASK & {16{armed_q}};
      take_clr = 16'd0;
      if (trap && x_interrupt_i && x_exception_cause_i[4])
         take_clr = 16'd1 << x_exception_cause_i[3:0];
      wr_clr = 16'd0;
      if (csr_we && (d_csr_sel_i == CSR_MIP))
         wr_clr = ~wdata[31:16];
      edge_d = (edge_set | (edge_q & ~wr_clr & ~take_clr)) & EDGE_MASK;
   end

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      csr_mie_d      = csr_mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      if (trap) begin
         mepc_d         = x_exception_pc_i & ~32'h3;
         mcause_d       = {x_interrupt_i, 26'd0, x_exception_cause_i};
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_we) begin
         case (d_csr_sel_i)
            CSR_MSTATUS: begin
               mstatus_mie_d  = wdata[3];
               mstatus_mpie_d = wdata[7];
            end
            CSR_MIE:      csr_mie_d  = wdata & MIE_MASK;
            CSR_MTVEC:    mtvec_d    = {wdata[31:2],
                             (g_VECTORED && (wdata[1:0] == 2'b01)) ? 2'b01 : 2'b00};
            CSR_MSCRATCH: mscratch_d = wdata;
            CSR_MEPC:     mepc_d     = wdata & ~32'h3;
            CSR_MCAUSE:   mcause_d   = wdata & 32'h8000_001F;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         csr_mie_q      <= 32'd0;
         mtvec_q        <= MTVEC_RST;
         mscratch_q     <= 32'd0;
         mepc_q         <= 32'd0;
         mcause_q       <= 32'd0;
         tick_q         <= 1'b0;
         irq_q          <= 16'd0;
         edge_q         <= 16'd0;
         armed_q        <= 1'b0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         csr_mie_q      <= csr_mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         tick_q         <= tick_i;
         irq_q          <= irq_in & IRQ_MASK;
         edge_q         <= edge_d;
         armed_q        <= 1'b1;
      end
   end

   always_comb begin
      mip_ext = ((edge_q & EDGE_MASK) | (irq_q & ~EDGE_MASK)) & IRQ_MASK;
      mip_r   = {mip_ext, 8'h00, tick_q, 7'h00};
      pend    = mip_r & csr_mie_q;
   end

   // Scan from the highest line down so the lowest pending index wins.
   always_comb begin
      irq_cause = 5'd0;
      if (pend[7])
         irq_cause = 5'd7;
      for (int n = 15; n >= 0; n--) begin
         if (pend[16+n])
            irq_cause = 5'(16 + n);
      end
   end

   always_comb begin
      vec_offset = 32'd0;
      if ((mtvec_q[1:0] == 2'b01) && x_interrupt_i)
         vec_offset = {25'd0, x_exception_cause_i, 2'b00};
   end

   assign irq_pending_o    = mstatus_mie_q & (|pend);
   assign irq_cause_o      = irq_cause;
   assign x_trap_vector_o  = {mtvec_q[31:2], 2'b00} + vec_offset;
   assign x_exception_pc_o = mepc_q;
   assign csr_mstatus_o    = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
   assign csr_mie_o        = csr_mie_q;
   assign csr_mip_o        = mip_r;
   assign csr_mtvec_o      = mtvec_q;
   assign csr_mscratch_o   = mscratch_q;
   assign csr_mepc_o       = mepc_q;
   assign csr_mcause_o     = mcause_q;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Directed bench for urv_trap_ctrl: 4 lines, line 1 edge-triggered, vectored mtvec allowed.
module tb_urv_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        x_stall_i, x_kill_i, d_is_csr_i, d_is_mret_i;
   logic [11:0] d_csr_sel_i;
   logic [31:0] x_csr_write_value_i;
   logic [3:0]  irq_i;
   logic        tick_i, x_exception_i, x_interrupt_i;
   logic [4:0]  x_exception_cause_i;
   logic [31:0] x_exception_pc_i;
   logic        irq_pending_o;
   logic [4:0]  irq_cause_o;
   logic [31:0] x_trap_vector_o, x_exception_pc_o;
   logic [31:0] csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mtvec_o;
   logic [31:0] csr_mscratch_o, csr_mepc_o, csr_mcause_o;

   int n_vec = 0;
   int n_err = 0;

   urv_trap_ctrl #(
      .g_NUM_IRQ    (4),
      .g_EDGE_MASK  (16'h0002),
      .g_VECTORED   (1'b1),
      .g_MTVEC_RESET(32'h0000_0008)
   ) dut (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .x_stall_i          (x_stall_i),
      .x_kill_i           (x_kill_i),
      .d_is_csr_i         (d_is_csr_i),
      .d_is_mret_i        (d_is_mret_i),
      .d_csr_sel_i        (d_csr_sel_i),
      .x_csr_write_value_i(x_csr_write_value_i),
      .irq_i              (irq_i),
      .tick_i             (tick_i),
      .x_exception_i      (x_exception_i),
      .x_interrupt_i      (x_interrupt_i),
      .x_exception_cause_i(x_exception_cause_i),
      .x_exception_pc_i   (x_exception_pc_i),
      .irq_pending_o      (irq_pending_o),
      .irq_cause_o        (irq_cause_o),
      .x_trap_vector_o    (x_trap_vector_o),
      .x_exception_pc_o   (x_exception_pc_o),
      .csr_mstatus_o      (csr_mstatus_o),
      .csr_mie_o          (csr_mie_o),
      .csr_mip_o          (csr_mip_o),
      .csr_mtvec_o        (csr_mtvec_o),
      .csr_mscratch_o     (csr_mscratch_o),
      .csr_mepc_o         (csr_mepc_o),
      .csr_mcause_o       (csr_mcause_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        csr, mret, stall, kill;
      logic [11:0] sel;
      logic [31:0] wd;
      logic [3:0]  irq;
      logic        tick, exc, intr;
      logic [4:0]  cause;
      logic [31:0] pc;
      logic [31:0] e_mstatus, e_mie, e_mip, e_mtvec, e_mepc, e_mcause, e_scr;
      logic        e_pend;
      logic [4:0]  e_cause;
      logic [31:0] e_vec;
   } vec_t;

   vec_t tbl [29];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic idle();
      d_is_csr_i = 1'b0; d_is_mret_i = 1'b0; x_stall_i = 1'b0; x_kill_i = 1'b0;
      d_csr_sel_i = 12'h000; x_csr_write_value_i = 32'h0; irq_i = 4'h0; tick_i = 1'b0;
      x_exception_i = 1'b0; x_interrupt_i = 1'b0; x_exception_cause_i = 5'd0; x_exception_pc_i = 32'h0;
   endtask

   task automatic chk_reset_vals(input int idx);
      chk("rst_mstatus", idx, csr_mstatus_o, 32'h0000_1800);
      chk("rst_mie", idx, csr_mie_o, 32'h0);
      chk("rst_mip", idx, csr_mip_o, 32'h0);
      chk("rst_mtvec", idx, csr_mtvec_o, 32'h0000_0008);
      chk("rst_mscratch", idx, csr_mscratch_o, 32'h0);
      chk("rst_mepc", idx, csr_mepc_o, 32'h0);
      chk("rst_mcause", idx, csr_mcause_o, 32'h0);
      chk("rst_pending", idx, {31'd0, irq_pending_o}, 32'h0);
      chk("rst_cause", idx, {27'd0, irq_cause_o}, 32'h0);
      chk("rst_exc_pc", idx, x_exception_pc_o, 32'h0);
   endtask

   initial begin
      // csr mret stall kill | sel | wd | irq | tick exc intr | cause | pc || mstatus mie mip mtvec mepc mcause scr pend cause vec
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'h0,     32'h0,     32'h8,    32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h8};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'h0,     32'h0,     32'h8,    32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h8};
      tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 12'h304, 32'h00010080, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'h10080, 32'h0,     32'h8,    32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h8};
      tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 12'h300, 32'h8,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'h10080, 32'h0,     32'h8,    32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h8};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b1,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'h10080, 32'h80,    32'h8,    32'h0,        32'h0,        32'h0,        1'b1, 5'd7,  32'h8};
      tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 12'h304, 32'hFFFFFFFF, 4'h5, 1'b1,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h50080, 32'h8,    32'h0,        32'h0,        32'h0,        1'b1, 5'd16, 32'h8};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h4, 1'b1,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h40080, 32'h8,    32'h0,        32'h0,        32'h0,        1'b1, 5'd18, 32'h8};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b1,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h80,    32'h8,    32'h0,        32'h0,        32'h0,        1'b1, 5'd7,  32'h8};
      tbl[8]  = '{1'b1,1'b0,1'b0,1'b0, 12'h305, 32'h00001001, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h0,     32'h1001, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b0, 12'h305, 32'h00002003, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h0,     32'h2000, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h2000};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0, 12'h305, 32'h00001001, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h0,     32'h1001, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b1,1'b1, 5'd16, 32'h123, 32'h1880, 32'hF0080, 32'h0,     32'h1001, 32'h120,      32'h80000010, 32'h0,        1'b0, 5'd0,  32'h1040};
      tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1888, 32'hF0080, 32'h0,     32'h1001, 32'h120,      32'h80000010, 32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b1,1'b0, 5'd2,  32'h202, 32'h1880, 32'hF0080, 32'h0,     32'h1001, 32'h200,      32'h2,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[14] = '{1'b1,1'b1,1'b0,1'b0, 12'h300, 32'h8,        4'h0, 1'b0,1'b1,1'b0, 5'd5,  32'h301, 32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h300,      32'h5,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[15] = '{1'b0,1'b1,1'b1,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h300,      32'h5,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[16] = '{1'b1,1'b0,1'b0,1'b1, 12'h300, 32'h8,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h300,      32'h5,        32'h0,        1'b0, 5'd0,  32'h1000};
      tbl[17] = '{1'b1,1'b0,1'b0,1'b0, 12'h340, 32'hDEADBEEF, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h300,      32'h5,        32'hDEADBEEF, 1'b0, 5'd0,  32'h1000};
      tbl[18] = '{1'b1,1'b0,1'b0,1'b0, 12'h341, 32'h12345677, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h12345674, 32'h5,        32'hDEADBEEF, 1'b0, 5'd0,  32'h1000};
      tbl[19] = '{1'b1,1'b0,1'b0,1'b0, 12'h342, 32'hFFFFFFFF, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h12345674, 32'h8000001F, 32'hDEADBEEF, 1'b0, 5'd0,  32'h1000};
      tbl[20] = '{1'b1,1'b0,1'b0,1'b0, 12'h3FF, 32'hFFFFFFFF, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h12345674, 32'h8000001F, 32'hDEADBEEF, 1'b0, 5'd0,  32'h1000};
      tbl[21] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h20000, 32'h1001, 32'h12345674, 32'h8000001F, 32'hDEADBEEF, 1'b0, 5'd17, 32'h1000};
      tbl[22] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h20000, 32'h1001, 32'h12345674, 32'h8000001F, 32'hDEADBEEF, 1'b0, 5'd17, 32'h1000};
      tbl[23] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h0, 1'b0,1'b1,1'b1, 5'd17, 32'h400, 32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h400,      32'h80000011, 32'hDEADBEEF, 1'b0, 5'd0,  32'h1044};
      tbl[24] = '{1'b0,1'b0,1'b0,1'b0, 12'h000, 32'h0,        4'h2, 1'b0,1'b1,1'b1, 5'd17, 32'h404, 32'h1800, 32'hF0080, 32'h20000, 32'h1001, 32'h404,      32'h80000011, 32'hDEADBEEF, 1'b0, 5'd17, 32'h1044};
      tbl[25] = '{1'b1,1'b0,1'b0,1'b0, 12'h344, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h0,     32'h1001, 32'h404,      32'h80000011, 32'hDEADBEEF, 1'b0, 5'd0,  32'h1000};
      tbl[26] = '{1'b1,1'b0,1'b0,1'b0, 12'h344, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h20000, 32'h1001, 32'h404,      32'h80000011, 32'hDEADBEEF, 1'b0, 5'd17, 32'h1000};
      tbl[27] = '{1'b1,1'b0,1'b0,1'b0, 12'h344, 32'hFFFFFFFF, 4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1800, 32'hF0080, 32'h20000, 32'h1001, 32'h404,      32'h80000011, 32'hDEADBEEF, 1'b0, 5'd17, 32'h1000};
      tbl[28] = '{1'b1,1'b0,1'b0,1'b0, 12'h300, 32'h8,        4'h0, 1'b0,1'b0,1'b0, 5'd0,  32'h0,   32'h1808, 32'hF0080, 32'h20000, 32'h1001, 32'h404,      32'h80000011, 32'hDEADBEEF, 1'b1, 5'd17, 32'h1000};

      // Line 1 held high through reset: must not be taken as an edge after release.
      idle();
      irq_i   = 4'h2;
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      chk_reset_vals(-1);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      for (int i = 0; i < 29; i++) begin
         @(negedge clk_i);
         d_is_csr_i = tbl[i].csr; d_is_mret_i = tbl[i].mret;
         x_stall_i = tbl[i].stall; x_kill_i = tbl[i].kill;
         d_csr_sel_i = tbl[i].sel; x_csr_write_value_i = tbl[i].wd;
         irq_i = tbl[i].irq; tick_i = tbl[i].tick;
         x_exception_i = tbl[i].exc; x_interrupt_i = tbl[i].intr;
         x_exception_cause_i = tbl[i].cause; x_exception_pc_i = tbl[i].pc;
         @(posedge clk_i);
         #1;
         chk("mstatus", i, csr_mstatus_o, tbl[i].e_mstatus);
         chk("mie", i, csr_mie_o, tbl[i].e_mie);
         chk("mip", i, csr_mip_o, tbl[i].e_mip);
         chk("mtvec", i, csr_mtvec_o, tbl[i].e_mtvec);
         chk("mepc", i, csr_mepc_o, tbl[i].e_mepc);
         chk("exc_pc", i, x_exception_pc_o, tbl[i].e_mepc);
         chk("mcause", i, csr_mcause_o, tbl[i].e_mcause);
         chk("mscratch", i, csr_mscratch_o, tbl[i].e_scr);
         chk("pending", i, {31'd0, irq_pending_o}, {31'd0, tbl[i].e_pend});
         chk("cause", i, {27'd0, irq_cause_o}, {27'd0, tbl[i].e_cause});
         chk("vector", i, x_trap_vector_o, tbl[i].e_vec);
      end

      // Asynchronous reset mid-cycle: values must settle before the next clock edge.
      @(negedge clk_i);
      idle();
      @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      irq_i   = 4'h2;
      #1;
      chk_reset_vals(100);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("post_rst_mip_a", 101, csr_mip_o, 32'h0);
      @(posedge clk_i);
      #1;
      chk("post_rst_mip_b", 102, csr_mip_o, 32'h0);
      chk("post_rst_mtvec", 102, csr_mtvec_o, 32'h0000_0008);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
